// File: rtl/mem_responder.sv
// Purpose : memory-side responder; accepts one MemR/MemW strobe at a time and
//           performs a single 16-bit word access on an internal RAM.
// Latency : request in cycle 0 -> done/err/rdata in cycle WAIT_CYCLES+2.
// Backpressure: strobes arriving while busy are ignored (no queueing); the
//           requester holds its state until done is seen.
//
// Ports:
//   CLK, Reset      clock (rising edge) and synchronous active-high reset
//   MemR, MemW      request strobes; exactly one high in IDLE starts an access
//   addr, wdata     byte address and write data, captured at acceptance
//   rdata           last completed read (registered)
//   done, err       one-cycle completion / error pulses (registered)
//   busy, state     decoded from the state register (IDLE=0, WAIT=1, ACCESS=2)
//
// Optional feature: define MEM_ALIGN_CHECK_EN to flag odd byte addresses as
// misaligned (access suppressed, done+err returned at the normal latency).
module mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemR,
    input  logic              MemW,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic [1:0]        state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        UNUSED = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt;
    logic [3:0]        wait_cnt;
    logic              op_wr;
    logic [ADDR_W-2:0] idx_q;
    logic [15:0]       wdata_q;
    logic              mis_q;
    logic              oor;
    logic              accept;
    logic              conflict;
    logic [AW-1:0]     ram_idx;

    logic [15:0] mem [DEPTH];

    assign accept   = (state_r == IDLE) && (MemR ^ MemW);
    assign conflict = (state_r == IDLE) && MemR && MemW;
    assign oor      = (32'(idx_q) >= 32'(DEPTH));
    assign ram_idx  = idx_q[AW-1:0];

    assign busy  = (state_r != IDLE);
    assign state = state_r;

    // Next-state logic
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (accept) begin
                    state_nxt = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;  // encoding 3 falls back silently
        endcase
    end

    // State, request capture and registered outputs
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r  <= IDLE;
            wait_cnt <= 4'd0;
            op_wr    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= 16'h0000;
            rdata    <= 16'h0000;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_r <= state_nxt;
            done    <= 1'b0;
            err     <= 1'b0;

            if (accept) begin
                op_wr    <= MemW;
                idx_q    <= addr[ADDR_W-1:1];
                wdata_q  <= wdata;
                wait_cnt <= CNT_LOAD;
            end else if (state_r == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (conflict) begin
                err <= 1'b1;
            end

            if (state_r == ACCESS) begin
                done <= 1'b1;
                err  <= oor | mis_q;
                // Misaligned reads leave rdata alone; out-of-range reads return 0.
                if (!op_wr && !mis_q) begin
                    rdata <= oor ? 16'h0000 : mem[ram_idx];
                end
            end
        end
    end

    // RAM write port; contents are deliberately not reset, and a reset on the
    // ACCESS edge suppresses the commit.
    always_ff @(posedge CLK) begin
        if (!Reset && state_r == ACCESS && op_wr && !oor && !mis_q) begin
            mem[ram_idx] <= wdata_q;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge CLK) begin
        if (Reset) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= addr[0];
        end
    end
`else
    // Byte-address LSB has no meaning without the alignment check.
    logic unused_addr_lsb;
    assign unused_addr_lsb = addr[0];
    assign mis_q           = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Purpose : directed self-checking bench for mem_responder (WAIT_CYCLES=1 and 0).
// Latency : checks done at WAIT_CYCLES+2 cycles after the request cycle.
// Backpressure: requests are issued only when the DUT is idle or in a done cycle.
module tb_mem_responder;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        MemR, MemW;
    logic [15:0] addr, wdata;
    logic [15:0] rdata;
    logic        done, err, busy;
    logic [1:0]  state;

    logic        MemR0, MemW0;
    logic [15:0] addr0, wdata0;
    logic [15:0] rdata0;
    logic        done0, err0, busy0;
    logic [1:0]  state0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mem_responder #(.ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(1)) u_dut (
        .CLK(CLK), .Reset(Reset), .MemR(MemR), .MemW(MemW), .addr(addr),
        .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
        .state(state)
    );

    mem_responder #(.ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .CLK(CLK), .Reset(Reset), .MemR(MemR0), .MemW(MemW0), .addr(addr0),
        .wdata(wdata0), .rdata(rdata0), .done(done0), .err(err0), .busy(busy0),
        .state(state0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one request on u_dut, return latency (cycles until done) and outputs.
    task automatic xact(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, output int lat, output logic e,
                        output logic [15:0] rq);
        MemR = rd; MemW = wr; addr = a; wdata = d; lat = 0;
        do begin
            tick();
            lat++;
            if (lat == 1) begin
                MemR = 1'b0; MemW = 1'b0;
            end
        end while (!done && lat < 20);
        e  = err;
        rq = rdata;
    endtask

    initial begin
        int          lat;
        logic        e;
        logic [15:0] rq;
        bit          saw_done;

        Reset = 1'b1;
        MemR = 0; MemW = 0; addr = 0; wdata = 0;
        MemR0 = 0; MemW0 = 0; addr0 = 0; wdata0 = 0;
        tick(); tick();
        Reset = 1'b0;

        // Reset values
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_err",   32'(err),   32'd0);
        chk("rst_rdata", 32'(rdata), 32'h0);

        // Write BEEF to 0x0010: busy cycles 1..2, done in cycle 3
        MemW = 1; addr = 16'h0010; wdata = 16'hBEEF;
        tick();
        MemW = 0;
        chk("w_c1_busy",  32'(busy),  32'd1);
        chk("w_c1_state", 32'(state), 32'd1);
        tick();
        chk("w_c2_state", 32'(state), 32'd2);
        chk("w_c2_done",  32'(done),  32'd0);
        tick();
        chk("w_c3_done",  32'(done),  32'd1);
        chk("w_c3_err",   32'(err),   32'd0);
        chk("w_c3_state", 32'(state), 32'd0);
        // Read issued in the done cycle
        xact(1, 0, 16'h0010, 16'h0, lat, e, rq);
        chk("r_lat",   32'(lat), 32'd3);
        chk("r_rdata", 32'(rq),  32'hBEEF);
        chk("r_err",   32'(e),   32'd0);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);

        // Conflict: both strobes in IDLE
        MemR = 1; MemW = 1; addr = 16'h0010; wdata = 16'h0000;
        tick();
        MemR = 0; MemW = 0;
        chk("cf_err",   32'(err),   32'd1);
        chk("cf_done",  32'(done),  32'd0);
        chk("cf_state", 32'(state), 32'd0);
        tick();
        chk("cf_err_clr", 32'(err), 32'd0);
        xact(1, 0, 16'h0010, 16'h0, lat, e, rq);
        chk("cf_ram", 32'(rq), 32'hBEEF);

        // Out of range: word index 1024
        xact(0, 1, 16'h0000, 16'h1234, lat, e, rq);
        xact(1, 0, 16'h0800, 16'h0, lat, e, rq);
        chk("oor_r_rdata", 32'(rq),   32'h0);
        chk("oor_r_err",   32'(e),    32'd1);
        chk("oor_r_done",  32'(done), 32'd1);
        xact(0, 1, 16'h0800, 16'hFFFF, lat, e, rq);
        chk("oor_w_err", 32'(e),   32'd1);
        chk("oor_w_lat", 32'(lat), 32'd3);
        xact(1, 0, 16'h0000, 16'h0, lat, e, rq);
        chk("oor_w_drop", 32'(rq), 32'h1234);

        // Reset during WAIT aborts the write
        MemW = 1; addr = 16'h0000; wdata = 16'hFFFF;
        tick();
        MemW = 0;
        chk("ab_wait", 32'(state), 32'd1);
        Reset = 1;
        tick();
        Reset = 0;
        chk("ab_state", 32'(state), 32'd0);
        chk("ab_busy",  32'(busy),  32'd0);
        chk("ab_rdata", 32'(rdata), 32'h0);
        saw_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) saw_done = 1;
            tick();
        end
        chk("ab_no_done", 32'(saw_done), 32'd0);
        xact(1, 0, 16'h0000, 16'h0, lat, e, rq);
        chk("ab_ram", 32'(rq), 32'h1234);

        // Odd byte address: word 1 preset, then write to addr 3
        xact(0, 1, 16'h0002, 16'h1111, lat, e, rq);
        xact(0, 1, 16'h0003, 16'h2222, lat, e, rq);
        chk("mis_lat", 32'(lat), 32'd3);
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_err", 32'(e), 32'd1);
        xact(1, 0, 16'h0002, 16'h0, lat, e, rq);
        chk("mis_word1", 32'(rq), 32'h1111);
`else
        chk("mis_err", 32'(e), 32'd0);
        xact(1, 0, 16'h0002, 16'h0, lat, e, rq);
        chk("mis_word1", 32'(rq), 32'h2222);
`endif

        // WAIT_CYCLES=0: back-to-back writes then reads, done every 2 cycles
        for (int i = 0; i < 8; i++) begin
            MemW0 = (i < 4); MemR0 = (i >= 4);
            addr0 = 16'((i % 4) * 2); wdata0 = 16'((i % 4) + 1);
            tick();
            MemW0 = 0; MemR0 = 0;
            chk("b2b_access", 32'(state0), 32'd2);
            tick();
            chk("b2b_done", 32'(done0), 32'd1);
            if (i >= 4) chk("b2b_rdata", 32'(rdata0), 32'((i % 4) + 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
